// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between a requester and alu_seq.
//   start, op, a, b            requester -> ALU  (request: opcode and operands)
//   busy, acc_update, X,       ALU -> requester  (status, result strobe,
//   zero, carry                                   registered result and flags)
// Modports: master = requester side, slave = ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             acc_update;
    logic [WIDTH-1:0] X;
    logic             zero;
    logic             carry;

    modport master (output start, op, a, b,
                    input  busy, acc_update, X, zero, carry);
    modport slave  (input  start, op, a, b,
                    output busy, acc_update, X, zero, carry);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU feeding the accumulator register.
// A start in IDLE captures op/a/b. Single-cycle ops go straight to DONE.
// MUL (op 111) runs WIDTH shift-add iterations in MULT and then enters DONE.
// DONE lasts one cycle and drives the acc_update strobe.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; aborts any operation in flight
//   bus  - alu_seq_if.slave carrying the signals below
//          start, op, a, b    request inputs
//          busy, acc_update   status outputs
//          X, zero, carry     registered result and flags
// Build option: define MUL_EN to build the multiplier. When MUL_EN is not
// defined, op 111 passes a through with carry=0 on the single-cycle path.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
`ifdef MUL_EN
        , MULT = 2'd2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    // single-cycle datapath, evaluated directly on the request inputs
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic [WIDTH:0]   sum, diff;

    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        diff  = {1'b0, bus.a} - {1'b0, bus.b};
        res   = '0;
        res_c = 1'b0;
        case (bus.op)
            3'b000: begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
            3'b001: begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end  // borrow
            3'b010: res = bus.a & bus.b;
            3'b011: res = bus.a | bus.b;
            3'b100: res = bus.a ^ bus.b;
            3'b101: begin res = bus.a << 1; res_c = bus.a[WIDTH-1]; end
            3'b110: begin res = bus.a >> 1; res_c = bus.a[0];       end
            3'b111: res = bus.a;  // pass-through when no multiplier is built
        endcase
    end

`ifdef MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;   // a, shifted left once per iteration
    logic [WIDTH-1:0]   mplier_q, mplier_d; // b, consumed LSB first
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] acc_sum;

    always_comb acc_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        zero_d  = zero_q;
        carry_d = carry_q;
`ifdef MUL_EN
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef MUL_EN
                    if (bus.op == 3'b111) begin
                        state_d  = MULT;
                        cnt_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        prod_d   = '0;
                    end else
`endif
                    begin
                        state_d = DONE;
                        x_d     = res;
                        zero_d  = (res == '0);
                        carry_d = res_c;
                    end
                end
            end
`ifdef MUL_EN
            MULT: begin
                prod_d   = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // final partial product lands in X directly, no extra cycle
                    state_d = DONE;
                    x_d     = acc_sum[WIDTH-1:0];
                    zero_d  = (acc_sum[WIDTH-1:0] == '0);
                    carry_d = |acc_sum[2*WIDTH-1:WIDTH];
                end
            end
`endif
            DONE:    state_d = IDLE;  // any start seen here is dropped
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
`ifdef MUL_EN
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
`ifdef MUL_EN
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
`endif
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_update = (state_q == DONE);
    assign bus.X          = x_q;
    assign bus.zero       = zero_q;
    assign bus.carry      = carry_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 8;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

`ifdef MUL_EN
    localparam bit HAS_MUL = 1'b1;
`else
    localparam bit HAS_MUL = 1'b0;
`endif

    // Reference: the result and flag of one operation, from the opcode table.
    task automatic ref_op(input logic [2:0] op, input longint a, input longint b,
                          output longint r, output bit c);
        longint t;
        c = 1'b0;
        case (op)
            3'd0: begin t = a + b; r = t & MASK; c = (t > MASK); end
            3'd1: begin r = (a - b) & MASK; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = (a * 2) & MASK; c = (a >= (longint'(1) << (W - 1))); end
            3'd6: begin r = a / 2; c = (a % 2) != 0; end
            default: begin
                if (HAS_MUL) begin t = a * b; r = t & MASK; c = (t > MASK); end
                else r = a;
            end
        endcase
    endtask

    // Behavioural model: a countdown of cycles left until the result is due.
    bit     m_valid = 1'b0;
    bit     m_done  = 1'b0;
    int     m_left  = 0;
    longint m_x = 0, p_x = 0;
    bit     m_z = 1'b0, m_c = 1'b0, p_c = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1; m_done = 1'b0; m_left = 0;
                m_x = 0; m_z = 1'b0; m_c = 1'b0;
            end else if (m_valid) begin
                if (m_done) begin
                    m_done = 1'b0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_x = p_x; m_c = p_c; m_z = (p_x == 0); m_done = 1'b1;
                    end
                end else if (bus.start) begin
                    ref_op(bus.op, longint'(bus.a), longint'(bus.b), p_x, p_c);
                    if (HAS_MUL && bus.op == 3'd7) m_left = W;
                    else begin
                        m_x = p_x; m_c = p_c; m_z = (p_x == 0); m_done = 1'b1;
                    end
                end
            end
            @(negedge clk);
            if (m_valid) begin
                chk("busy", bus.busy, (m_done || m_left > 0));
                chk("acc_update", bus.acc_update, m_done);
                chk("X", bus.X, m_x[W-1:0]);
                chk("zero", bus.zero, m_z);
                chk("carry", bus.carry, m_c);
            end
        end
    end

    // Directed request with hand-computed expectations; called at a negedge.
    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ex, input bit ec, input bit ez,
                       input int ebusy, input bit pulse);
        int  nbusy;
        bit  got;
        nbusy = 0;
        got   = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 3'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) nbusy++;
            if (bus.acc_update) begin got = 1'b1; break; end
            bus.start = (pulse && i == 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("acc_update seen", got, 1'b1);
        chk("lit X", bus.X, ex);
        chk("lit carry", bus.carry, ec);
        chk("lit zero", bus.zero, ez);
        chk("lit busy cycles", nbusy, ebusy);
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst X", bus.X, 8'h00);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst acc_update", bus.acc_update, 1'b0);
        chk("rst zero", bus.zero, 1'b0);
        chk("rst carry", bus.carry, 1'b0);

        run(3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1, 1'b0);
        run(3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1, 1'b0);
        run(3'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1, 1'b0);
        run(3'd5, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1, 1'b0);
        run(3'd6, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1, 1'b0);
        run(3'd4, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
`ifdef MUL_EN
        run(3'd7, 8'd12, 8'd13, 8'h9C, 1'b0, 1'b0, W + 1, 1'b0);
        run(3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, W + 1, 1'b1);
        run(3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, W + 1, 1'b0);
        // reset during the fourth MULT cycle aborts the multiply
        bus.start = 1'b1; bus.op = 3'd7; bus.a = 8'h0F; bus.b = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort X", bus.X, 8'h00);
        for (int i = 0; i < W + 3; i++) begin
            chk("abort no acc_update", bus.acc_update, 1'b0);
            @(negedge clk);
        end
        run(3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1, 1'b0);
`else
        run(3'd7, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
`endif

        // random traffic: dense starts (many dropped while busy), rare resets
        for (int n = 0; n < 1500; n++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 3'($urandom);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
